// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared types and constants for the two-core divider arbiter
package fp_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      BUSY,
      RESP
   } arb_state_t;

   localparam logic [31:0] QNAN               = 32'h7FC0_0000;
   localparam int          WDOG_LIMIT_DEFAULT = 63;

endpackage

// File: rtl/fp_arb_rr2.sv
// rtl/fp_arb_rr2.sv - two-way round-robin pick; on a tie the core that did not go last wins
module fp_arb_rr2 (
   input  logic [1:0] eligible,
   input  logic       last_gnt,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |eligible;
      winner = eligible[1];
      if (eligible == 2'b11) begin
         winner = ~last_gnt;
      end
   end

endmodule

// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - shares one FP divider between two cores with flush and watchdog abort
module fp_div_arbiter
   import fp_arb_pkg::*;
#(
   parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
   input  logic        in_Clk,
   input  logic        in_Rst,
   input  logic        in_req0,
   input  logic        in_req1,
   input  logic [31:0] in_numA0,
   input  logic [31:0] in_numA1,
   input  logic [31:0] in_numB0,
   input  logic [31:0] in_numB1,
   input  logic        in_flush0,
   input  logic        in_flush1,
   output logic        out_stall0,
   output logic        out_stall1,
   output logic        out_done0,
   output logic        out_done1,
   output logic        out_err0,
   output logic        out_err1,
   output logic [31:0] out_result0,
   output logic [31:0] out_result1,
   output logic        out_div_start,
   output logic [31:0] out_div_numA,
   output logic [31:0] out_div_numB,
   input  logic        in_div_stall,
   input  logic [31:0] in_div_result
);

   localparam logic [5:0] WDOG_LAST = 6'(WDOG_LIMIT - 1);

   arb_state_t  state, state_d;
   logic        owner, last_gnt;
   logic [31:0] result_q;
   logic [5:0]  wdog_cnt;
   logic        err_q, cancel_q;
   logic [1:0]  eligible;
   logic        rr_winner, rr_valid;
   logic        flush_owner, wdog_hit, resp_ok;

   assign eligible = {in_req1 & ~in_flush1, in_req0 & ~in_flush0};

   fp_arb_rr2 u_rr (
      .eligible (eligible),
      .last_gnt (last_gnt),
      .winner   (rr_winner),
      .valid    (rr_valid)
   );

   always_comb begin
      state_d       = state;
      out_div_start = 1'b0;
      flush_owner   = owner ? in_flush1 : in_flush0;
      wdog_hit      = in_div_stall && (wdog_cnt == WDOG_LAST);
      case (state)
         IDLE:     if (rr_valid) state_d = ISSUE;
         ISSUE: begin
            out_div_start = 1'b1;
            state_d       = WAIT_ACK;
         end
         WAIT_ACK: state_d = BUSY;
         BUSY:     if (!in_div_stall || wdog_hit) state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      // A flush landing on the RESP cycle itself must still swallow the result
      resp_ok     = (state == RESP) && !cancel_q && !flush_owner;
      out_done0   = resp_ok && !owner;
      out_done1   = resp_ok && owner;
      out_err0    = out_done0 && err_q;
      out_err1    = out_done1 && err_q;
      out_result0 = out_done0 ? result_q : 32'h0;
      out_result1 = out_done1 ? result_q : 32'h0;
      out_stall0  = in_req0 && !out_done0;
      out_stall1  = in_req1 && !out_done1;
   end

   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         state        <= IDLE;
         owner        <= 1'b0;
         last_gnt     <= 1'b1;
         out_div_numA <= 32'h0;
         out_div_numB <= 32'h0;
         result_q     <= 32'h0;
         wdog_cnt     <= 6'd0;
         err_q        <= 1'b0;
         cancel_q     <= 1'b0;
      end else begin
         state <= state_d;
         if ((state == ISSUE || state == WAIT_ACK || state == BUSY) && flush_owner) begin
            cancel_q <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (rr_valid) begin
                  owner        <= rr_winner;
                  out_div_numA <= rr_winner ? in_numA1 : in_numA0;
                  out_div_numB <= rr_winner ? in_numB1 : in_numB0;
               end
            end
            BUSY: begin
               if (!in_div_stall) begin
                  result_q <= in_div_result;
               end else begin
                  wdog_cnt <= wdog_cnt + 6'd1;
                  if (wdog_hit) begin
                     result_q <= QNAN;
                     err_q    <= 1'b1;
                  end
               end
            end
            RESP: begin
               last_gnt <= owner;
               wdog_cnt <= 6'd0;
               err_q    <= 1'b0;
               cancel_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb/tb_fp_div_arbiter.sv - randomized bench with a timeline model of the divider arbiter
module tb_fp_div_arbiter;

   localparam int WDOG = 63;

   logic        in_Clk = 1'b0;
   logic        in_Rst = 1'b1;
   logic [1:0]  req    = 2'b00;
   logic [1:0]  flush  = 2'b00;
   logic [31:0] na [2];
   logic [31:0] nb [2];
   logic        in_req0, in_req1, in_flush0, in_flush1;
   logic [31:0] in_numA0, in_numA1, in_numB0, in_numB1;
   logic        in_div_stall  = 1'b0;
   logic [31:0] in_div_result = 32'h0;
   logic        out_stall0, out_stall1, out_done0, out_done1, out_err0, out_err1;
   logic [31:0] out_result0, out_result1;
   logic        out_div_start;
   logic [31:0] out_div_numA, out_div_numB;

   assign in_req0   = req[0];
   assign in_req1   = req[1];
   assign in_flush0 = flush[0];
   assign in_flush1 = flush[1];
   assign in_numA0  = na[0];
   assign in_numA1  = na[1];
   assign in_numB0  = nb[0];
   assign in_numB1  = nb[1];

   logic [1:0]  o_done, o_err, o_stall;
   logic [31:0] o_res [2];
   assign o_done  = {out_done1, out_done0};
   assign o_err   = {out_err1, out_err0};
   assign o_stall = {out_stall1, out_stall0};
   assign o_res[0] = out_result0;
   assign o_res[1] = out_result1;

   fp_div_arbiter dut (
      .in_Clk        (in_Clk),
      .in_Rst        (in_Rst),
      .in_req0       (in_req0),
      .in_req1       (in_req1),
      .in_numA0      (in_numA0),
      .in_numA1      (in_numA1),
      .in_numB0      (in_numB0),
      .in_numB1      (in_numB1),
      .in_flush0     (in_flush0),
      .in_flush1     (in_flush1),
      .out_stall0    (out_stall0),
      .out_stall1    (out_stall1),
      .out_done0     (out_done0),
      .out_done1     (out_done1),
      .out_err0      (out_err0),
      .out_err1      (out_err1),
      .out_result0   (out_result0),
      .out_result1   (out_result1),
      .out_div_start (out_div_start),
      .out_div_numA  (out_div_numA),
      .out_div_numB  (out_div_numB),
      .in_div_stall  (in_div_stall),
      .in_div_result (in_div_result)
   );

   always #5 in_Clk = ~in_Clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Operation timeline: grant cycle, completion cycle, owner and outcome
   bit          m_busy   = 0;
   int          m_owner  = 0;
   int          m_last   = 1;
   int          m_g      = 0;
   int          m_dc     = 0;
   int          m_n      = 0;
   bit          m_err    = 0;
   bit          m_cancel = 0;
   logic [31:0] m_a, m_b, m_res, m_dres;

   int          div_rem  = 0;
   logic [31:0] div_res  = 32'h0;
   int          forced_n = 0;
   logic [31:0] forced_res = 32'h0;

   logic [1:0]  last_done = 2'b00;
   int          ops_left [2];
   int          dn_cnt [2];
   int          dn_first [2];
   int          dn_last [2];
   logic [31:0] dn_res [2];
   logic        dn_err [2];
   int          st_cnt, st_last;
   logic [31:0] st_a;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic int pick_n();
      int r;
      r = $urandom_range(0, 19);
      case (r)
         0:       return 1;
         1:       return 2;
         2:       return 63;
         3:       return 64;
         4:       return 300;
         default: return $urandom_range(1, 25);
      endcase
   endfunction

   task automatic clear_mon();
      for (int k = 0; k < 2; k++) begin
         dn_cnt[k] = 0; dn_first[k] = -1; dn_last[k] = -1; dn_res[k] = 32'h0; dn_err[k] = 1'b0;
      end
      st_cnt = 0; st_last = -1; st_a = 32'h0;
   endtask

   task automatic step();
      logic [1:0]  ed, ee, elig;
      logic [31:0] er [2];
      logic        es;
      int          w;
      in_div_stall  = (div_rem > 0);
      in_div_result = div_res;
      @(negedge in_Clk);
      es = 1'b0; ed = 2'b00; ee = 2'b00; er[0] = 32'h0; er[1] = 32'h0;
      if (!in_Rst) begin
         if (m_busy && cyc > m_g && cyc <= m_dc && flush[m_owner]) m_cancel = 1;
         es = m_busy && (cyc == m_g + 1);
         if (m_busy && cyc == m_dc && !m_cancel) begin
            ed[m_owner] = 1'b1;
            ee[m_owner] = m_err;
            er[m_owner] = m_res;
         end
      end
      chk("start", 32'(out_div_start), 32'(es));
      if (in_Rst || es) begin
         chk("div_numA", out_div_numA, in_Rst ? 32'h0 : m_a);
         chk("div_numB", out_div_numB, in_Rst ? 32'h0 : m_b);
      end
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("done%0d", k), 32'(o_done[k]), 32'(ed[k]));
         chk($sformatf("err%0d", k), 32'(o_err[k]), 32'(ee[k]));
         chk($sformatf("result%0d", k), o_res[k], er[k]);
         chk($sformatf("stall%0d", k), 32'(o_stall[k]), 32'(req[k] & ~ed[k]));
         if (o_done[k]) begin
            dn_cnt[k]++;
            if (dn_first[k] < 0) dn_first[k] = cyc;
            dn_last[k] = cyc;
            dn_res[k]  = o_res[k];
            dn_err[k]  = o_err[k];
         end
      end
      if (out_div_start) begin
         st_cnt++; st_last = cyc; st_a = out_div_numA;
      end
      last_done = ed;
      if (in_Rst) begin
         m_busy = 0; m_last = 1; m_cancel = 0; div_rem = 0;
      end else begin
         if (div_rem > 0) div_rem--;
         if (es) begin
            div_rem = m_n;
            div_res = m_dres;
         end
         if (m_busy && cyc == m_dc) begin
            m_busy = 0;
            m_last = m_owner;
         end else if (!m_busy) begin
            elig = req & ~flush;
            if (elig != 2'b00) begin
               if (elig == 2'b11) w = 1 - m_last;
               else w = elig[1] ? 1 : 0;
               m_busy = 1; m_owner = w; m_g = cyc; m_cancel = 0;
               m_a = na[w]; m_b = nb[w];
               m_n = (forced_n > 0) ? forced_n : pick_n();
               m_dres = (forced_n > 0) ? forced_res
                                       : (na[w] ^ {nb[w][15:0], nb[w][31:16]}) + 32'h1357;
               if (m_n - 1 >= WDOG) begin
                  m_dc = cyc + 3 + WDOG; m_err = 1; m_res = 32'h7FC0_0000;
               end else begin
                  m_dc = cyc + m_n + 3; m_err = 0; m_res = m_dres;
               end
            end
         end
      end
      @(posedge in_Clk);
      #1;
      cyc++;
   endtask

   task automatic run_directed(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (last_done[k] && ops_left[k] > 0) begin
               ops_left[k]--;
               if (ops_left[k] == 0) req[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic do_reset();
      in_Rst = 1'b1; req = 2'b00; flush = 2'b00;
      step();
      in_Rst = 1'b0;
      clear_mon();
   endtask

   task automatic single_op(input int n, input logic [31:0] res, output int g);
      do_reset();
      forced_n = n; forced_res = res;
      na[0] = 32'h40C0_0000; nb[0] = 32'h4000_0000;
      ops_left[0] = 1; ops_left[1] = 0;
      g = cyc; req[0] = 1'b1;
   endtask

   initial begin
      int g;
      na[0] = 32'h0; na[1] = 32'h0; nb[0] = 32'h0; nb[1] = 32'h0;
      ops_left[0] = 0; ops_left[1] = 0;
      clear_mon();
      step();
      in_Rst = 1'b0;

      // Single divide, 13 stall cycles
      single_op(13, 32'h4040_0000, g);
      run_directed(22);
      chk("op_starts", st_cnt, 1);
      chk("op_start_cyc", st_last - g, 1);
      chk("op_start_numA", st_a, 32'h40C0_0000);
      chk("op_done_lat", dn_first[0] - g, 16);
      chk("op_done_res", dn_res[0], 32'h4040_0000);
      chk("op_done_err", 32'(dn_err[0]), 0);
      chk("op_stall_after", 32'(out_stall0), 0);

      // Ties from reset: core0, then core1 while core0 re-requests, then core0
      do_reset();
      forced_n = 5; forced_res = 32'h3F80_0000;
      na[0] = 32'h1111_0000; na[1] = 32'h2222_0000; nb[0] = 32'h1; nb[1] = 32'h2;
      ops_left[0] = 2; ops_left[1] = 1;
      g = cyc; req = 2'b11;
      run_directed(40);
      chk("tie_done0_first", dn_first[0] - g, 8);
      chk("tie_done1", dn_first[1] - g, 17);
      chk("tie_done0_second", dn_last[0] - g, 26);
      chk("tie_starts", st_cnt, 3);

      // Owner flushed mid-BUSY; pending core0 takes over after the silent RESP
      do_reset();
      forced_n = 20; forced_res = 32'h4100_0000;
      ops_left[0] = 1; ops_left[1] = 1;
      g = cyc; req[1] = 1'b1;
      run_directed(2);
      req[0] = 1'b1;
      run_directed(8);
      req[1] = 1'b0; flush[1] = 1'b1;
      run_directed(1);
      flush[1] = 1'b0;
      run_directed(19);
      chk("flush_no_done1", dn_cnt[1], 0);
      chk("flush_next_start", st_last - g, 25);
      run_directed(30);
      chk("flush_done0", dn_first[0] - g, 47);

      // Watchdog: permanent stall, and the 63/64 stall boundary
      single_op(1000, 32'h4000_0000, g);
      run_directed(70);
      chk("wdog_lat", dn_first[0] - g, 66);
      chk("wdog_err", 32'(dn_err[0]), 1);
      chk("wdog_res", dn_res[0], 32'h7FC0_0000);
      single_op(63, 32'h3F80_0000, g);
      run_directed(70);
      chk("n63_lat", dn_first[0] - g, 66);
      chk("n63_err", 32'(dn_err[0]), 0);
      chk("n63_res", dn_res[0], 32'h3F80_0000);
      single_op(64, 32'h3F80_0000, g);
      run_directed(70);
      chk("n64_err", 32'(dn_err[0]), 1);
      chk("n64_res", dn_res[0], 32'h7FC0_0000);

      // Reset in the middle of BUSY
      single_op(30, 32'h4200_0000, g);
      run_directed(10);
      in_Rst = 1'b1; req = 2'b00;
      #1;
      chk("rst_async_numA", out_div_numA, 32'h0);
      chk("rst_async_stall0", 32'(out_stall0), 0);
      step();
      in_Rst = 1'b0;
      run_directed(40);
      chk("rst_no_done", dn_cnt[0], 0);
      forced_n = 4; ops_left[0] = 1;
      g = cyc; req[0] = 1'b1;
      run_directed(10);
      chk("rst_after_start", st_last - g, 1);
      chk("rst_after_done", dn_first[0] - g, 7);

      // Back-to-back from the same core
      single_op(3, 32'h4080_0000, g);
      ops_left[0] = 2;
      run_directed(20);
      chk("b2b_done_cnt", dn_cnt[0], 2);
      chk("b2b_first_done", dn_first[0] - g, 6);
      chk("b2b_restart", st_last - dn_first[0], 2);

      // Random traffic against the timeline model
      do_reset();
      forced_n = 0;
      for (int i = 0; i < 4000; i++) begin
         for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0;
            if (!req[k]) begin
               if ($urandom_range(0, 5) == 0) begin
                  req[k] = 1'b1; na[k] = $urandom; nb[k] = $urandom;
               end
            end else if (last_done[k]) begin
               if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
               else begin
                  na[k] = $urandom; nb[k] = $urandom;
               end
            end else if ($urandom_range(0, 59) == 0) begin
               flush[k] = 1'b1; req[k] = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
               flush[k] = 1'b1;
            end
         end
         if ($urandom_range(0, 1499) == 0) begin
            in_Rst = 1'b1; req = 2'b00; flush = 2'b00;
         end
         step();
         in_Rst = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
